// File: rtl/stream_mux_if.sv
// stream_mux_if -- handshake bundle for the N-channel streaming multiplexer.
//
// Parameters:
//   CH  number of input channels
//   DW  data width in bits
//
// Signals:
//   in_valid  [CH]     per-channel beat valid             (producer -> mux)
//   in_ready  [CH]     per-channel accept, combinational  (mux -> producer)
//   in_data   [CH*DW]  channel i in bits [i*DW +: DW]     (producer -> mux)
//   in_last   [CH]     per-channel end-of-packet flag     (producer -> mux)
//   out_valid          output register holds a beat       (mux -> consumer)
//   out_ready          consumer accepts the beat          (consumer -> mux)
//   out_data  [DW]     registered data                    (mux -> consumer)
//   out_last           registered last flag               (mux -> consumer)
//   out_ch    [CW]     source channel of the held beat    (mux -> consumer)
//
// Modports: master = producers/consumer side, slave = the multiplexer.
interface stream_mux_if #(
  parameter int CH = 4,
  parameter int DW = 8
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0]    in_valid;
  logic [CH-1:0]    in_ready;
  logic [CH*DW-1:0] in_data;
  logic [CH-1:0]    in_last;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic [CW-1:0]    out_ch;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch
  );
endinterface

// File: rtl/stream_mux.sv
// stream_mux -- N-channel valid/ready multiplexer with round-robin arbitration
// and a one-deep registered output.
//
// Parameters:
//   CH  number of input channels (2..16)
//   DW  data width in bits (>= 1)
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    stream_mux_if.slave: in_valid/in_ready/in_data/in_last per channel,
//          out_valid/out_ready/out_data/out_last/out_ch towards the consumer
//
// Optional feature: define STREAM_MUX_PKT_LOCK_EN to hold the grant on one
// channel from the first beat of a packet until its in_last beat. Without the
// macro arbitration is per beat and in_last is only carried to out_last.
module stream_mux #(
  parameter int CH = 4,
  parameter int DW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  stream_mux_if.slave bus
);
  localparam int CW = $clog2(CH);

  // Advance a channel index with an exact wrap at CH-1 (CH need not be 2^n).
  function automatic logic [CW-1:0] inc_wrap(input logic [CW-1:0] c);
    if (int'(c) == CH - 1) return '0;
    return c + 1'b1;
  endfunction

  // Channel index base+k, folded back into 0..CH-1.
  function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= CH) s = s - CH;
    return CW'(s);
  endfunction

  logic [CW-1:0] ptr;
  logic          vld_p1;
  logic [DW-1:0] data_p1;
  logic          last_p1;
  logic [CW-1:0] ch_p1;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic          locked;
  logic [CW-1:0] lock_ch;
`endif

  logic          load_en;
  logic          gnt_vld;
  logic [CW-1:0] grant_ch;
  logic [CW-1:0] cand;
  logic [CH-1:0] grant;
  logic [DW-1:0] sel_data;
  logic          sel_last;
  logic          xfer;

  assign load_en = !vld_p1 || bus.out_ready;

  always_comb begin
    gnt_vld  = 1'b0;
    grant_ch = '0;
    cand     = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    // A packet in flight owns the output even while its producer stalls.
    if (locked) begin
      grant_ch = lock_ch;
      gnt_vld  = bus.in_valid[lock_ch];
    end else
`endif
    begin
      for (int k = 0; k < CH; k++) begin
        cand = rr_idx(ptr, k);
        if (!gnt_vld && bus.in_valid[cand]) begin
          gnt_vld  = 1'b1;
          grant_ch = cand;
        end
      end
    end
    grant = gnt_vld ? (CH'(1) << grant_ch) : '0;
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (grant[i]) begin
        sel_data = bus.in_data[i*DW +: DW];
        sel_last = bus.in_last[i];
      end
    end
  end

  assign xfer         = gnt_vld && load_en;
  assign bus.in_ready = {CH{load_en && rst_n}} & grant;

  // ---- stage p1: output register, loaded from the granted channel ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      ch_p1   <= '0;
      ptr     <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      locked  <= 1'b0;
      lock_ch <= '0;
`endif
    end else if (load_en) begin
      if (xfer) begin
        vld_p1  <= 1'b1;
        data_p1 <= sel_data;
        last_p1 <= sel_last;
        ch_p1   <= grant_ch;
        // While locked the pointer is rewritten with the same value each beat,
        // so it effectively holds until the closing beat.
        ptr     <= inc_wrap(grant_ch);
`ifdef STREAM_MUX_PKT_LOCK_EN
        locked  <= !sel_last;
        lock_ch <= grant_ch;
`endif
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_last  = last_p1;
  assign bus.out_ch    = ch_p1;
endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux -- scoreboard bench for stream_mux (CH=4, DW=8).
// A producer process feeds per-channel beat queues onto the interface; the
// main process issues directed vectors and pushes the hand-ordered expected
// output beats; a monitor pops and compares every beat the consumer takes.
module tb_stream_mux;
  localparam int CH = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [1:0] ch;
    logic       last;
    logic [7:0] data;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  stream_mux_if #(.CH(CH), .DW(DW)) bus ();

  stream_mux #(.CH(CH), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_vec = 0;
  int         n_bad = 0;
  beat_t      exp_q[$];
  logic [8:0] chq[CH][$];
  int         grant_cnt[CH];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Producers: present queue heads, retire a head once it was accepted.
  initial begin : producer
    logic [CH-1:0]    fire;
    logic [CH-1:0]    v;
    logic [CH-1:0]    l;
    logic [CH*DW-1:0] d;
    logic [8:0]       h;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.in_last  = '0;
    forever begin
      @(negedge clk);
      fire = bus.in_valid & bus.in_ready;
      @(posedge clk);
      #1;
      v = '0;
      l = '0;
      d = '0;
      for (int c = 0; c < CH; c++) begin
        if (fire[c] && chq[c].size() > 0) void'(chq[c].pop_front());
        if (chq[c].size() > 0) begin
          h           = chq[c][0];
          v[c]        = 1'b1;
          l[c]        = h[8];
          d[c*DW +: DW] = h[7:0];
        end
      end
      bus.in_valid = v;
      bus.in_last  = l;
      bus.in_data  = d;
    end
  end

  // Monitor: every beat taken by the consumer is checked against the queue.
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        grant_cnt[bus.out_ch]++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_beat: got ch %0d data %0h, required no beat",
                   bus.out_ch, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("beat{ch,last,data}", 32'({bus.out_ch, bus.out_last, bus.out_data}), 32'(e));
        end
      end
    end
  end

  task automatic drive_pt();
    @(posedge clk);
    #3;
  endtask

  task automatic samp_pt();
    @(negedge clk);
  endtask

  task automatic send(input int c, input logic [7:0] d, input logic l);
    chq[c].push_back({l, d});
  endtask

  task automatic expect_beat(input int c, input logic [7:0] d, input logic l);
    beat_t b;
    b.ch   = 2'(c);
    b.last = l;
    b.data = d;
    exp_q.push_back(b);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      samp_pt();
      if (exp_q.size() == 0 && bus.in_valid == '0 && bus.out_valid == 1'b0) break;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bus.out_ready = 1'b1;
    for (int c = 0; c < CH; c++) grant_cnt[c] = 0;

    // Reset and idle
    #1 rst_n = 1'b0;
    samp_pt();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_ch",    32'(bus.out_ch),    32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    drive_pt();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      samp_pt();
      check("idle", 32'({bus.out_valid, bus.in_ready, bus.out_data, bus.out_ch}), 32'd0);
    end

    // Single channel streaming on ch2
    drive_pt();
    send(2, 8'h11, 1'b0); send(2, 8'h22, 1'b0); send(2, 8'h33, 1'b1);
    expect_beat(2, 8'h11, 1'b0); expect_beat(2, 8'h22, 1'b0); expect_beat(2, 8'h33, 1'b1);
    samp_pt();
    samp_pt();
    check("t2_in_ready", 32'(bus.in_ready), 32'(4'b0100));
    samp_pt();
    check("t2_beat1", 32'({bus.out_valid, bus.out_ch, bus.out_data}), 32'({1'b1, 2'd2, 8'h11}));
    samp_pt();
    check("t2_beat2", 32'({bus.out_valid, bus.out_ch, bus.out_data}), 32'({1'b1, 2'd2, 8'h22}));
    samp_pt();
    check("t2_beat3", 32'({bus.out_valid, bus.out_ch, bus.out_data}), 32'({1'b1, 2'd2, 8'h33}));
    wait_drain("t2_drain", 20);

    // Round-robin fairness: pointer sits at 3 after the ch2 stream
    drive_pt();
    for (int c = 0; c < CH; c++) grant_cnt[c] = 0;
    for (int k = 0; k < 25; k++) begin
      for (int j = 0; j < CH; j++) begin
        int c;
        c = (3 + j) % CH;
        send(c, 8'(c * 64 + k), 1'b1);
        expect_beat(c, 8'(c * 64 + k), 1'b1);
      end
    end
    wait_drain("t3_drain", 200);
    check("t3_share_ch0", 32'(grant_cnt[0]), 32'd25);
    check("t3_share_ch1", 32'(grant_cnt[1]), 32'd25);
    check("t3_share_ch2", 32'(grant_cnt[2]), 32'd25);
    check("t3_share_ch3", 32'(grant_cnt[3]), 32'd25);

    // Backpressure on ch1
    drive_pt();
    bus.out_ready = 1'b0;
    send(1, 8'hA5, 1'b1); send(1, 8'h5A, 1'b1);
    expect_beat(1, 8'hA5, 1'b1); expect_beat(1, 8'h5A, 1'b1);
    samp_pt();
    samp_pt();
    check("t4_in_ready", 32'(bus.in_ready), 32'(4'b0010));
    for (int i = 0; i < 5; i++) begin
      samp_pt();
      check("t4_hold{valid,ready,data}", 32'({bus.out_valid, bus.in_ready, bus.out_data}),
            32'({1'b1, 4'b0000, 8'hA5}));
    end
    drive_pt();
    bus.out_ready = 1'b1;
    samp_pt();
    check("t4_release_in_ready", 32'(bus.in_ready), 32'(4'b0010));
    samp_pt();
    check("t4_next_beat", 32'({bus.out_valid, bus.out_data}), 32'({1'b1, 8'h5A}));
    wait_drain("t4_drain", 20);

    // Packet on ch0 with ch1 competing; pointer sits at 2
    drive_pt();
    send(0, 8'h01, 1'b0); send(0, 8'h02, 1'b0); send(0, 8'h03, 1'b1);
    send(1, 8'h81, 1'b1); send(1, 8'h82, 1'b1);
`ifdef STREAM_MUX_PKT_LOCK_EN
    expect_beat(0, 8'h01, 1'b0); expect_beat(0, 8'h02, 1'b0); expect_beat(0, 8'h03, 1'b1);
    expect_beat(1, 8'h81, 1'b1); expect_beat(1, 8'h82, 1'b1);
`else
    expect_beat(0, 8'h01, 1'b0); expect_beat(1, 8'h81, 1'b1); expect_beat(0, 8'h02, 1'b0);
    expect_beat(1, 8'h82, 1'b1); expect_beat(0, 8'h03, 1'b1);
`endif
    wait_drain("t5_drain", 30);

    // Reset mid-stream with a held beat (and an open packet when locking)
    drive_pt();
    bus.out_ready = 1'b0;
    send(2, 8'h77, 1'b0); send(2, 8'h78, 1'b1);
    samp_pt();
    samp_pt();
    samp_pt();
    check("t6_loaded", 32'({bus.out_valid, bus.out_data}), 32'({1'b1, 8'h77}));
    drive_pt();
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_in_ready",  32'(bus.in_ready),  32'd0);
    chq[2].delete();
    send(3, 8'h33, 1'b1); send(1, 8'h11, 1'b1);
    expect_beat(1, 8'h11, 1'b1); expect_beat(3, 8'h33, 1'b1);
    bus.out_ready = 1'b1;
    samp_pt();
    samp_pt();
    check("t6_in_ready_in_reset", 32'(bus.in_ready), 32'd0);
    drive_pt();
    rst_n = 1'b1;
    samp_pt();
    check("t6_first_grant", 32'(bus.in_ready), 32'(4'b0010));
    wait_drain("t6_drain", 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
